// File: rtl/apb_bridge_pkg22.sv
// Shared types and constants for the APB master bridge.
package apb_bridge_pkg22;

  localparam int SLOT_W     = 4;
  localparam int MAX_SLAVES = 16;
  localparam int RSP_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // One response record at the default read-data width.
  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

  // One-hot select line for a slot number.
  function automatic logic [MAX_SLAVES-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
    logic [MAX_SLAVES-1:0] sel;
    sel       = '0;
    sel[slot] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt22.sv
// Wait-state counter for the ACCESS phase. Cleared before ACCESS, counts
// cycles without pready and saturates instead of wrapping. "expired" flags
// the last permitted ACCESS cycle so the FSM can give up on that edge.
module apb_timeout_cnt22 #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    // Timeout disabled: nothing to count.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, clear, enable};
    assign expired       = 1'b0;
  end else begin : g_cnt
    localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;

    // Count stalled ACCESS cycles, holding at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (clear) begin
        cnt <= '0;
      end else if (enable && (cnt != SAT)) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign expired = (cnt == LAST);
  end

endmodule

// File: rtl/apb_master_bridge22.sv
// APB master bridge: turns a valid/ready request into one APB transfer at a
// time and returns the result on a valid/ready response channel.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// SETUP  | psel asserted, penable low, address/control driven
// ACCESS | penable high, waiting for pready or timeout
// RESP   | rsp_valid high until rsp_ready
module apb_master_bridge22
  import apb_bridge_pkg22::*;
#(
  parameter int PADDR_WIDTH22  = 32,
  parameter int PWDATA_WIDTH22 = 32,
  parameter int PRDATA_WIDTH22 = 32,
  parameter int NUM_SLAVES     = 16,
  parameter int SLOT_LSB       = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      pclock22,
  input  logic                      preset22,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [PADDR_WIDTH22-1:0]  req_addr,
  input  logic                      req_write,
  input  logic [PWDATA_WIDTH22-1:0] req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [PRDATA_WIDTH22-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [PADDR_WIDTH22-1:0]  paddr22,
  output logic                      prwd22,
  output logic [PWDATA_WIDTH22-1:0] pwdata22,
  output logic [MAX_SLAVES-1:0]     psel22,
  output logic                      penable22,
  input  logic [PRDATA_WIDTH22-1:0] prdata22,
  input  logic                      pslverr22,
  input  logic                      pready22
);

  state_t            state;
  logic [SLOT_W-1:0] req_slot;
  logic              cnt_clear;
  logic              cnt_enable;
  logic              cnt_expired;

  assign req_slot   = req_addr[SLOT_LSB +: SLOT_W];
  assign cnt_clear  = (state == SETUP);
  assign cnt_enable = (state == ACCESS) && !pready22;

  apb_timeout_cnt22 #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (pclock22),
    .rst_n  (preset22),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  // Transfer sequencing with all outputs registered.
  always_ff @(posedge pclock22 or negedge preset22) begin
    if (!preset22) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr22     <= '0;
      prwd22      <= 1'b0;
      pwdata22    <= '0;
      psel22      <= '0;
      penable22   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (int'(req_slot) < NUM_SLAVES) begin
              paddr22  <= req_addr;
              prwd22   <= req_write;
              pwdata22 <= req_wdata;
              psel22   <= slot_onehot(req_slot);
              state    <= SETUP;
            end else begin
              // Unpopulated slot: answer with an error, never touch the bus.
              rsp_valid   <= 1'b1;
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              state       <= RESP;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          penable22 <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          // pready on the timeout cycle still counts as a normal completion.
          if (pready22) begin
            psel22      <= '0;
            penable22   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= (prwd22 || pslverr22) ? '0 : prdata22;
            rsp_err     <= pslverr22;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (cnt_expired) begin
            psel22      <= '0;
            penable22   <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge22.sv
// Testbench for apb_master_bridge22: directed cases followed by random
// transfers, each checked cycle by cycle against a transaction-level model.
module tb_apb_master_bridge22;
  import apb_bridge_pkg22::*;

  localparam int NS = 4;
  localparam int TO = 8;

  logic        pclock22 = 1'b0;
  logic        preset22 = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr22;
  logic        prwd22;
  logic [31:0] pwdata22;
  logic [15:0] psel22;
  logic        penable22;
  logic [31:0] prdata22 = '0;
  logic        pslverr22 = 1'b0;
  logic        pready22 = 1'b0;

  int checks = 0;
  int errors = 0;

  apb_master_bridge22 #(
    .PADDR_WIDTH22(32), .PWDATA_WIDTH22(32), .PRDATA_WIDTH22(32),
    .NUM_SLAVES(NS), .SLOT_LSB(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclock22(pclock22), .preset22(preset22),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr22(paddr22), .prwd22(prwd22), .pwdata22(pwdata22),
    .psel22(psel22), .penable22(penable22),
    .prdata22(prdata22), .pslverr22(pslverr22), .pready22(pready22)
  );

  always #5 pclock22 = ~pclock22;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One transfer. w = ACCESS cycles with pready low before it rises (w >= TO
  // means it never rises); hold = cycles rsp_ready stays low in RESP.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int w, input logic [31:0] rd, input logic se, input int hold);
    int          slot;
    int          n_acc;
    int          rsp_cyc;
    int          guard;
    logic        dec_err;
    logic        tmo;
    logic [15:0] exp_sel;
    rsp_t        exp_r;

    slot    = int'(addr[15:12]);
    dec_err = (slot >= NS);
    tmo     = !dec_err && (w >= TO);
    exp_sel = dec_err ? 16'h0 : 16'(1 << slot);
    n_acc   = dec_err ? 0 : (tmo ? TO : w + 1);
    rsp_cyc = dec_err ? 1 : n_acc + 2;
    exp_r.err     = dec_err || tmo || se;
    exp_r.timeout = tmo;
    exp_r.rdata   = (dec_err || tmo || wr || se) ? 32'h0 : rd;

    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge pclock22);
      guard++;
    end
    check("req_ready_idle", {63'h0, req_ready}, 64'h1);

    req_valid = 1'b1;
    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    @(posedge pclock22);

    for (int cyc = 1; cyc < rsp_cyc; cyc++) begin
      @(negedge pclock22);
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_write = 1'($urandom_range(0, 1));
      check("req_ready_busy", {63'h0, req_ready}, 64'h0);
      check("rsp_valid_busy", {63'h0, rsp_valid}, 64'h0);
      check("psel_bus", {48'h0, psel22}, {48'h0, exp_sel});
      check("penable_bus", {63'h0, penable22}, {63'h0, cyc > 1});
      check("paddr_bus", {32'h0, paddr22}, {32'h0, addr});
      check("prwd_bus", {63'h0, prwd22}, {63'h0, wr});
      check("pwdata_bus", {32'h0, pwdata22}, {32'h0, wd});
      if (cyc == 1) begin
        pready22  = 1'($urandom_range(0, 1));
        prdata22  = $urandom;
        pslverr22 = 1'($urandom_range(0, 1));
      end else if (cyc - 1 == w + 1) begin
        pready22  = 1'b1;
        prdata22  = rd;
        pslverr22 = se;
      end else begin
        pready22  = 1'b0;
        prdata22  = $urandom;
        pslverr22 = 1'($urandom_range(0, 1));
      end
    end

    for (int h = 0; h <= hold; h++) begin
      @(negedge pclock22);
      req_valid = 1'b0;
      pready22  = 1'($urandom_range(0, 1));
      prdata22  = $urandom;
      pslverr22 = 1'($urandom_range(0, 1));
      check("rsp_valid", {63'h0, rsp_valid}, 64'h1);
      check("rsp_rdata", {32'h0, rsp_rdata}, {32'h0, exp_r.rdata});
      check("rsp_err", {63'h0, rsp_err}, {63'h0, exp_r.err});
      check("rsp_timeout", {63'h0, rsp_timeout}, {63'h0, exp_r.timeout});
      check("psel_resp", {48'h0, psel22}, 64'h0);
      check("penable_resp", {63'h0, penable22}, 64'h0);
      check("req_ready_resp", {63'h0, req_ready}, 64'h0);
      rsp_ready = (h == hold);
    end
    @(negedge pclock22);
    rsp_ready = 1'b0;
    check("rsp_valid_done", {63'h0, rsp_valid}, 64'h0);
    check("req_ready_done", {63'h0, req_ready}, 64'h1);
  endtask

  initial begin
    #1 preset22 = 1'b0;
    #2;
    check("rst_req_ready", {63'h0, req_ready}, 64'h0);
    check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("rst_psel", {48'h0, psel22}, 64'h0);
    check("rst_penable", {63'h0, penable22}, 64'h0);
    check("rst_paddr", {32'h0, paddr22}, 64'h0);
    repeat (2) @(negedge pclock22);
    preset22 = 1'b1;
    check("rel_req_ready_pre", {63'h0, req_ready}, 64'h0);
    @(negedge pclock22);
    check("rel_req_ready_post", {63'h0, req_ready}, 64'h1);

    // zero-wait write, 3-wait read, slave error, decode error, timeout,
    // pready on the timeout cycle, response backpressure
    run_txn(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0);
    run_txn(32'h0000_3010, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, 0);
    run_txn(32'h0000_2000, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 0);
    run_txn(32'h0000_5000, 1'b1, 32'h5555_AAAA, 0, 32'h0, 1'b0, 0);
    run_txn(32'h0000_0040, 1'b0, 32'h0, 20, 32'h0, 1'b0, 0);
    run_txn(32'h0000_0044, 1'b0, 32'h0, 7, 32'h0BAD_CAFE, 1'b0, 0);
    run_txn(32'h0000_1100, 1'b0, 32'h0, 2, 32'hA5A5_0F0F, 1'b0, 5);

    // reset during ACCESS
    pready22  = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_2008;
    req_write = 1'b0;
    @(posedge pclock22);
    @(negedge pclock22);
    req_valid = 1'b0;
    @(negedge pclock22);
    check("mid_penable", {63'h0, penable22}, 64'h1);
    #2 preset22 = 1'b0;
    #1;
    check("mid_rst_psel", {48'h0, psel22}, 64'h0);
    check("mid_rst_penable", {63'h0, penable22}, 64'h0);
    check("mid_rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    repeat (2) @(negedge pclock22);
    preset22 = 1'b1;
    check("mid_rel_req_ready_pre", {63'h0, req_ready}, 64'h0);
    @(negedge pclock22);
    check("mid_rel_req_ready", {63'h0, req_ready}, 64'h1);
    check("mid_rel_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("mid_rel_psel", {48'h0, psel22}, 64'h0);

    // random transfers
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      a        = $urandom;
      a[15:12] = 4'($urandom_range(0, 5));
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 10)),
              $urandom, 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
